// File: rtl/booth_multiplier_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM state encoding,
// default operand width and a helper for sizing the iteration counter.
package booth_multiplier_pkg;

   localparam int DEFAULT_N = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EXAM  = 3'd2,
      S_ADD   = 3'd3,
      S_SUB   = 3'd4,
      S_SHIFT = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/booth_counter.sv
// Loadable down counter that tracks the remaining Booth iterations;
// tc flags the final iteration (count == 1).
module booth_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic         en,
   input  logic [W-1:0] init,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (ld) begin
         count <= init;
      end else if (en) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == W'(1));

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier for signed N-bit operands producing a
// signed 2N-bit product; one EXAM/optional ADD-SUB/SHIFT pass per bit.
module booth_multiplier
   import booth_multiplier_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           ready,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = cnt_width(N);

   state_t       state;
   logic [N:0]   a;
   logic [N:0]   m;
   logic [N-1:0] q;
   logic         q_1;
   logic         cnt_ld;
   logic         cnt_en;
   logic         cnt_tc;

   assign cnt_ld = (state == S_LOAD);
   assign cnt_en = (state == S_SHIFT);

   booth_counter #(
      .W (CW)
   ) u_booth_counter (
      .clk  (clk),
      .rst  (rst),
      .ld   (cnt_ld),
      .en   (cnt_en),
      .init (CW'(N)),
      .tc   (cnt_tc)
   );

   // ready/done are registered copies of the next-state decode, so they
   // stay pure functions of the current state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ready   <= 1'b1;
         done    <= 1'b0;
         product <= '0;
         a       <= '0;
         m       <= '0;
         q       <= '0;
         q_1     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_LOAD;
                  ready <= 1'b0;
               end
            end
            S_LOAD: begin
               a     <= '0;
               q     <= multiplier;
               q_1   <= 1'b0;
               m     <= {multiplicand[N-1], multiplicand};
               state <= S_EXAM;
            end
            S_EXAM: begin
               case ({q[0], q_1})
                  2'b10:   state <= S_SUB;
                  2'b01:   state <= S_ADD;
                  default: state <= S_SHIFT;
               endcase
            end
            S_ADD: begin
               a     <= a + m;
               state <= S_SHIFT;
            end
            S_SUB: begin
               a     <= a - m;
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               a   <= {a[N], a[N:1]};
               q   <= {a[0], q[N-1:1]};
               q_1 <= q[0];
               if (cnt_tc) begin
                  // The post-shift {A[N-1:0],Q} equals {A,Q[N-1:1]} now, so the
                  // product is already valid throughout the DONE cycle.
                  product <= {a, q[N-1:1]};
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  state <= S_EXAM;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 The block SHALL have parameter N, default 8, giving operand width in bits, with N >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port multiplicand, input, N bits, signed two's-complement operand M; captured in LOAD.
REQ-006 The block SHALL have port multiplier, input, N bits, signed two's-complement operand Q; captured in LOAD.
REQ-007 The block SHALL have port ready, output, 1 bit, high only in IDLE.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse in DONE.
REQ-009 The block SHALL have port product, output, 2N bits, signed result; registered and held until the next DONE.

Function
REQ-010 The block SHALL implement radix-2 Booth multiplication with these registers: A (N+1 bits, sign-extended accumulator), Q (N bits), Q_1 (1 bit), M (N+1 bits, sign-extended) and a down counter CNT.
REQ-011 The FSM SHALL have the states IDLE, LOAD, EXAM, ADD, SUB, SHIFT and DONE.
REQ-012 In IDLE, the FSM SHALL go to LOAD if start=1 and stay in IDLE otherwise.
REQ-013 LOAD SHALL set A=0, Q=multiplier, Q_1=0, M=sext(multiplicand) and CNT=N, then go to EXAM.
REQ-014 EXAM SHALL be purely a decision state with no register update, branching on {Q[0],Q_1}: 10 goes to SUB, 01 goes to ADD, and 00 or 11 goes to SHIFT.
REQ-015 SUB SHALL perform A<=A-M and ADD SHALL perform A<=A+M, both in N+1-bit modulo arithmetic, and both SHALL then go to SHIFT.
REQ-016 SHIFT SHALL arithmetically right-shift {A,Q,Q_1} by one, with A[N] replicated into the vacated bit, and SHALL decrement CNT.
REQ-017 SHIFT SHALL go to DONE when the pre-decrement CNT equals 1, and SHALL go to EXAM otherwise.
REQ-018 DONE SHALL set product<={A[N-1:0],Q}, assert done for exactly that cycle, and then go to IDLE.
REQ-019 Latency from the start-sampling edge to the done cycle SHALL be 2 + 2N + k cycles, where k is the number of ADD/SUB operations (0..N).
REQ-020 An assertion of start outside IDLE SHALL be ignored.
REQ-021 If start is held high continuously, a new operation SHALL begin on each IDLE cycle, giving back-to-back operation with one IDLE cycle between the done pulse and the next LOAD.
REQ-022 Operand inputs SHALL be don't-care except in the LOAD cycle.
REQ-023 The product for M = -2^(N-1), Q = -2^(N-1) SHALL be +2^(2N-2), with no overflow.
REQ-024 The outputs ready and done SHALL be decoded from the state only (Moore outputs).

Reset
REQ-025 While rst=1, the FSM SHALL be in IDLE and the block SHALL drive ready=1, done=0 and product=0, with A, Q, Q_1, M and CNT all 0.
REQ-026 A reset asserted mid-operation SHALL abort the operation immediately and asynchronously, with no done pulse and product cleared.
REQ-027 After rst is released, the first rising clock edge SHALL be able to sample start.

Structure
REQ-028 A shared package SHALL hold the state enumeration (3-bit encoding) and the default width constant.
REQ-029 The block SHALL contain one sub-module, booth_counter: a parameterised down counter with inputs ld, en and init, and a terminal output tc that is high when the count equals 1.
REQ-030 The FSM and the datapath SHALL reside in booth_multiplier.

Verification
REQ-031 With N=8, M=3, Q=5 and a start pulse, the bench SHALL see product=0x000F and done in the 22nd cycle after the sampling edge (k=4).
REQ-032 With M=-3 (0xFD) and Q=5, the bench SHALL see product=0xFFF1 (-15).
REQ-033 With M=0x80 and Q=0x80, the bench SHALL see product=0x4000; with M=0x7F and Q=0x80, product=0xC080.
REQ-034 With M=0x5A and Q=0, the bench SHALL see product=0x0000, with latency 18 cycles (k=0) and done for exactly one cycle.
REQ-035 Asserting rst at cycle 7 of an operation SHALL give ready=1, done=0 and product=0 immediately; the next start with 2x2 SHALL give 0x0004.
REQ-036 With start held high and two operand pairs presented at the successive LOAD cycles, the bench SHALL see two done pulses with the correct products, and any start pulses during the busy period SHALL have no effect.
